dff_reg_arbiter: RTL
====================

Name: dff_reg_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one WIDTH-bit register among N_REQ write requesters. The register is a bank of D flip-flops with synchronous reset.
- Grants exclusive write ownership. The owner may hold it for up to MAX_HOLD consecutive cycles.
- Hands over back-to-back to the next requester with no bubble.
- Sits between requesting datapath blocks and the shared state register; Q is the register output consumed downstream.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, register/data width in bits.
- MAX_HOLD, 4, maximum consecutive owned cycles per grant (>=1).

Ports:
- CLK  input  1  clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester write request, level-held.
- wdata  input  N_REQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  N_REQ  one-hot ownership, registered.
- busy  output  1  high while in OWN state.
- Q  output  WIDTH  shared register contents.

Behaviour:
- Reset (CLK edge with reset=1): state=IDLE, grant=0, busy=0, Q=0, ptr=0, hold_cnt=0. Reset overrides all other activity, including mid-ownership; pending writes are discarded.
- Internal state: state in {IDLE, OWN}, ptr (round-robin start index, clog2(N_REQ) bits), hold_cnt (0..MAX_HOLD-1), owner o = index of the set grant bit.
- Winner search: first set bit of the candidate mask scanning ptr, ptr+1, ... mod N_REQ.
- IDLE:
  - grant=0.
  - At the edge, if |req: grant<=onehot(winner), hold_cnt<=0, state<=OWN.
  - Otherwise stay in IDLE.
  - Request-to-grant latency is 1 cycle.
- OWN, owner o:
  - Write: at the edge, if req[o]=1 then Q<=wdata[o]. Q never loads from a non-owner. Q holds when req[o]=0.
  - Release condition: req[o]=0, or hold_cnt==MAX_HOLD-1.
  - On release: ptr<=(o+1) mod N_REQ.
    - If |req, then in the same edge grant<=onehot(winner), searched from the new ptr, using req as sampled at that edge; hold_cnt<=0; stay in OWN.
    - Otherwise grant<=0 and state<=IDLE.
  - No release: hold_cnt<=hold_cnt+1, grant unchanged.
- The release-cycle write still occurs when req[o]=1, so the owner gets exactly MAX_HOLD writes per grant.
- Sole requester hitting MAX_HOLD: search wraps back to o, so it is re-granted continuously. grant stays constant and hold_cnt restarts at 0.
- First write lands on the edge after grant rises (grant-to-Q latency 1 cycle).
- busy = (state==OWN). grant is nonzero iff busy; grant is never multi-hot.
- wdata of non-owners and X on non-owner lanes must not affect Q.

Test Plan (N_REQ=4, WIDTH=8, MAX_HOLD=4):
1. Reset: hold reset=1 for 2 edges with req=4'b1111 -> grant=0, busy=0, Q=8'h00.
2. Single requester: req=4'b0010, wdata lane1=8'hA5 -> grant=4'b0010 after edge 1, Q=8'hA5 after edge 2. Drop req[1] -> grant=0, busy=0 after the next edge; Q stays 8'hA5.
3. Full contention: req=4'b1111, lane i = 8'h10+i, all held:
   - grant=0001 for 4 cycles, then 0010, 0100, 1000, 0001 with no idle cycle between owners.
   - Q steps 8'h10, 8'h11, 8'h12, 8'h13.
4. Hold limit, sole requester: req=4'b0100 held 10 cycles with lane2 incrementing each cycle from 8'h00 -> grant=4'b0100 continuously, busy=1 throughout. Q tracks lane2 with 1-cycle lag (final Q=8'h09).
5. Early release plus fairness: req=4'b0011, owner 0 drops req[0] after 2 writes -> the next edge grants 4'b0010. Re-raising req[0] does not preempt owner 1 before its release.
6. Reset mid-ownership: assert reset while grant=4'b0100 -> next edge gives grant=0, Q=0, ptr=0. Deassert with req=4'b1100 -> grant=4'b0100 one edge later.

Source files
------------

// File: rtl/dff_reg_arbiter.sv
// Round-robin owner of a shared WIDTH-bit register: one requester at a time may write Q,
// for at most MAX_HOLD consecutive cycles, with bubble-free handover to the next requester.
module dff_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic [WIDTH-1:0]         Q
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               busy_q, busy_d;

    logic [PW-1:0]      owner;
    logic [PW-1:0]      next_ptr;
    logic               owner_req;
    logic               release_now;

    // First set candidate bit scanning start, start+1, ... wrapping modulo N_REQ.
    function automatic logic [N_REQ-1:0] pick(input logic [N_REQ-1:0] cand,
                                             input logic [PW-1:0] start);
        logic [N_REQ-1:0] oh;
        logic             found;
        int               idx;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(start) + k) % N_REQ;
            if (!found && cand[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [PW-1:0] to_index(input logic [N_REQ-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        q_d         = q_q;
        owner       = to_index(grant_q);
        owner_req   = req[owner];
        next_ptr    = PW'((int'(owner) + 1) % N_REQ);
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick(req, ptr_q);
                    hold_d  = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (owner_req) q_d = wdata[int'(owner)*WIDTH +: WIDTH];
                release_now = !owner_req || (hold_q == HW'(MAX_HOLD - 1));
                // On release the search starts past the old owner, so a sole requester wraps back to itself.
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (|req) begin
                        grant_d = pick(req, next_ptr);
                        hold_d  = '0;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == OWN);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign Q     = q_q;

endmodule
